// File: rtl/xorpar_pkg.sv
// Shared types and constants for the masked-parity frame streamer.
package xorpar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } frame_state_t;

    localparam int         DEFAULT_WIDTH = 7;
    localparam logic [6:0] DEFAULT_MASK  = 7'b1101111;

endpackage

// File: rtl/masked_xor_reduce.sv
// Combinational parity of the data bits selected by MASK; an all-zero mask yields 0.
module masked_xor_reduce
    import xorpar_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MASK  = DEFAULT_MASK
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^(data & MASK);

endmodule

// File: rtl/xorpar_stream.sv
// Streams words into per-frame masked parity and word count, with a one-deep
// word stage and a one-deep result register under valid/ready handshakes.
module xorpar_stream
    import xorpar_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MASK  = DEFAULT_MASK,
    parameter int               ODD   = 0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    localparam logic             ODD_BIT = (ODD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             word_par;
    logic             s1_valid;
    logic             s1_par;
    logic             s1_last;
    logic             drain;
    logic             accept;

    frame_state_t     state;
    frame_state_t     state_next;
    logic             acc;
    logic             acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             frame_acc;
    logic [CNT_W-1:0] frame_cnt;
    logic             out_valid_next;
    logic             out_parity_next;
    logic [CNT_W-1:0] out_count_next;

    masked_xor_reduce #(
        .WIDTH (WIDTH),
        .MASK  (MASK)
    ) u_reduce (
        .data   (in_data),
        .parity (word_par)
    );

    // A last word may only leave stage 1 if the result register is free or being emptied.
    assign drain    = s1_valid && (!s1_last || !out_valid || out_ready);
    assign in_ready = !s1_valid || drain;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_par   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_par   <= word_par;
            s1_last  <= in_last;
        end else if (drain) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_count  <= '0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            out_valid  <= out_valid_next;
            out_parity <= out_parity_next;
            out_count  <= out_count_next;
        end
    end

    // IDLE means no open frame, so a word arriving there starts from zero.
    always_comb begin
        frame_acc       = (state == ACC) ? acc : 1'b0;
        frame_cnt       = (state == ACC) ? cnt : '0;
        state_next      = state;
        acc_next        = acc;
        cnt_next        = cnt;
        out_valid_next  = out_valid;
        out_parity_next = out_parity;
        out_count_next  = out_count;

        if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (drain) begin
            if (s1_last) begin
                out_valid_next  = 1'b1;
                out_parity_next = frame_acc ^ s1_par ^ ODD_BIT;
                out_count_next  = sat_inc(frame_cnt);
                acc_next        = 1'b0;
                cnt_next        = '0;
                state_next      = IDLE;
            end else begin
                acc_next   = frame_acc ^ s1_par;
                cnt_next   = sat_inc(frame_cnt);
                state_next = ACC;
            end
        end
    end

endmodule
